// File: rtl/sar_adc_pkg.sv
// Shared definitions for the SAR ADC scan controller.
//   state_e    : controller state encoding (idle, sampling, converting)
//   clog2_min1 : ceil(log2(n)) with a floor of 1, used to size channel/counter fields
package sar_adc_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSample,
    StConvert
  } state_e;

  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) r++;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/sar_adc_bitseq.sv
// Successive-approximation bit sequencer: owns the trial-bit shift register and the
// DAC trial code.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clr_i         : clear trial code and shift register (highest priority)
//   load_i        : start a conversion with only the MSB set
//   step_i        : resolve the current trial bit using comp_i, move to the next bit
//   comp_i        : comparator, 1 = trial code above input (drop current bit)
//   dac_o         : current trial code
//   code_o        : code that results from resolving the current bit this cycle
//   last_o        : the current trial bit is the LSB
module sar_adc_bitseq #(
  parameter int unsigned Bits = 6
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clr_i,
  input  logic            load_i,
  input  logic            step_i,
  input  logic            comp_i,
  output logic [Bits-1:0] dac_o,
  output logic [Bits-1:0] code_o,
  output logic            last_o
);

  localparam logic [Bits-1:0] Msb = {1'b1, {(Bits - 1){1'b0}}};

  logic [Bits-1:0] sr_q;
  logic [Bits-1:0] dac_q;

  // On the LSB step sr_q >> 1 is zero, so code_o is the fully resolved result.
  assign code_o = (comp_i ? (dac_q & ~sr_q) : dac_q) | (sr_q >> 1);
  assign last_o = sr_q[0];
  assign dac_o  = dac_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sr_q  <= '0;
      dac_q <= '0;
    end else if (clr_i) begin
      sr_q  <= '0;
      dac_q <= '0;
    end else if (load_i) begin
      sr_q  <= Msb;
      dac_q <= Msb;
    end else if (step_i) begin
      sr_q  <= sr_q >> 1;
      dac_q <= code_o;
    end
  end

endmodule

// File: rtl/sar_adc_scan.sv
// SAR ADC controller with channel mux, programmable sample time and single/scan modes.
//   Clk, Rst_n : clock, asynchronous active-low reset
//   Start      : begin a request (accepted only when idle); Scan/ChanSel sampled with it
//   Scan       : 1 = convert channels 0..Channels-1 in order, 0 = convert ChanSel only
//   ChanSel    : single-mode channel, clamped to Channels-1
//   Abort      : synchronous return to idle, no Done, results retained
//   Comp       : comparator, 1 = trial code above input
//   Chan       : mux select
//   Sample     : sample switch closed
//   Dac        : trial code to capacitor array
//   Busy       : request in progress
//   Done       : one-cycle strobe, Result/ResultChan/Last valid
//   Last       : with Done, final channel of the request
//   Result     : last completed code
//   ResultChan : channel of Result
module sar_adc_scan
  import sar_adc_pkg::*;
#(
  parameter int unsigned Bits         = 6,
  parameter int unsigned Channels     = 4,
  parameter int unsigned SampleCycles = 1,
  parameter int unsigned ChanW        = clog2_min1(Channels)
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic             Scan,
  input  logic [ChanW-1:0] ChanSel,
  input  logic             Abort,
  input  logic             Comp,
  output logic [ChanW-1:0] Chan,
  output logic             Sample,
  output logic [Bits-1:0]  Dac,
  output logic             Busy,
  output logic             Done,
  output logic             Last,
  output logic [Bits-1:0]  Result,
  output logic [ChanW-1:0] ResultChan
);

  localparam int unsigned      CntW     = clog2_min1(SampleCycles);
  localparam logic [CntW-1:0]  CntInit  = CntW'(SampleCycles - 1);
  localparam logic [ChanW-1:0] ChanLast = ChanW'(Channels - 1);

  state_e          state_q;
  logic            scan_q;
  logic [CntW-1:0] cnt_q;

  logic             seq_clr;
  logic             seq_load;
  logic             seq_step;
  logic             seq_last;
  logic [Bits-1:0]  seq_code;
  logic [ChanW-1:0] sel_clamped;
  logic             final_chan;

  always_comb begin
    sel_clamped = ChanSel;
    if (32'(ChanSel) >= Channels) sel_clamped = ChanLast;
  end

  assign final_chan = !scan_q || (Chan == ChanLast);
  assign Busy       = (state_q != StIdle);

  // The sequencer is cleared on the final bit so Dac reads 0 while the next
  // channel samples (or once idle).
  always_comb begin
    seq_clr  = Abort || ((state_q == StConvert) && seq_last);
    seq_load = !Abort && (state_q == StSample) && (cnt_q == '0);
    seq_step = !Abort && (state_q == StConvert);
  end

  sar_adc_bitseq #(
    .Bits(Bits)
  ) u_bitseq (
    .clk_i (Clk),
    .rst_ni(Rst_n),
    .clr_i (seq_clr),
    .load_i(seq_load),
    .step_i(seq_step),
    .comp_i(Comp),
    .dac_o (Dac),
    .code_o(seq_code),
    .last_o(seq_last)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q    <= StIdle;
      scan_q     <= 1'b0;
      cnt_q      <= '0;
      Chan       <= '0;
      Sample     <= 1'b0;
      Done       <= 1'b0;
      Last       <= 1'b0;
      Result     <= '0;
      ResultChan <= '0;
    end else begin
      Done <= 1'b0;
      Last <= 1'b0;
      if (Abort) begin
        state_q <= StIdle;
        Sample  <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (Start) begin
              state_q <= StSample;
              scan_q  <= Scan;
              Chan    <= Scan ? '0 : sel_clamped;
              Sample  <= 1'b1;
              cnt_q   <= CntInit;
            end
          end
          StSample: begin
            if (cnt_q == '0) begin
              state_q <= StConvert;
              Sample  <= 1'b0;
            end else begin
              cnt_q <= cnt_q - CntW'(1);
            end
          end
          StConvert: begin
            if (seq_last) begin
              Result     <= seq_code;
              ResultChan <= Chan;
              Done       <= 1'b1;
              Last       <= final_chan;
              if (final_chan) begin
                state_q <= StIdle;
              end else begin
                state_q <= StSample;
                Chan    <= Chan + ChanW'(1);
                Sample  <= 1'b1;
                cnt_q   <= CntInit;
              end
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sar_adc_scan.sv
// Self-checking bench for sar_adc_scan: comparator modelled as Comp = (Dac > vin[Chan]);
// expected waveforms are computed cycle by cycle from the request timeline.
module tb_sar_adc_scan;

  localparam int unsigned Bits         = 6;
  localparam int unsigned Channels     = 4;
  localparam int unsigned SampleCycles = 3;
  localparam int unsigned ChanW        = 2;
  localparam int          Period       = SampleCycles + Bits;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             scan_in;
  logic [ChanW-1:0] chan_sel;
  logic             abort;
  logic             comp;
  logic [ChanW-1:0] chan;
  logic             sample;
  logic [Bits-1:0]  dac;
  logic             busy;
  logic             done;
  logic             last;
  logic [Bits-1:0]  result;
  logic [ChanW-1:0] result_chan;

  int vin [Channels];
  int total;
  int bad;
  int exp_result;
  int exp_rchan;

  sar_adc_scan #(
    .Bits        (Bits),
    .Channels    (Channels),
    .SampleCycles(SampleCycles)
  ) dut (
    .Clk       (clk),
    .Rst_n     (rst_n),
    .Start     (start),
    .Scan      (scan_in),
    .ChanSel   (chan_sel),
    .Abort     (abort),
    .Comp      (comp),
    .Chan      (chan),
    .Sample    (sample),
    .Dac       (dac),
    .Busy      (busy),
    .Done      (done),
    .Last      (last),
    .Result    (result),
    .ResultChan(result_chan)
  );

  assign comp = (int'(dac) > vin[chan]);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Binary search: code presented at step j given the bits already settled against v.
  function automatic int trial(input int v, input int j);
    int acc;
    acc = 0;
    for (int k = Bits - 1; k > Bits - 1 - j; k--) begin
      if ((acc | (1 << k)) <= v) acc = acc | (1 << k);
    end
    return acc | (1 << (Bits - 1 - j));
  endfunction

  function automatic int eff_chan(input int sel);
    int s;
    s = sel % (1 << ChanW);
    return (s >= Channels) ? Channels - 1 : s;
  endfunction

  // Drive one request and check every output on each cycle; Start is re-asserted
  // (and ignored) on the edge after poke_e.
  task automatic run_req(input bit scan, input int sel, input int poke_e);
    int n;
    int i;
    int r;
    int chans[Channels];
    n = scan ? Channels : 1;
    for (int k = 0; k < Channels; k++) chans[k] = scan ? k : eff_chan(sel);
    @(negedge clk);
    start    = 1'b1;
    scan_in  = scan;
    chan_sel = ChanW'(sel);
    for (int e = 0; e <= n * Period; e++) begin
      @(posedge clk);
      #1;
      start    = (e == poke_e);
      chan_sel = ChanW'($urandom);
      scan_in  = 1'($urandom);
      i = e / Period;
      r = e % Period;
      if (e > 0 && r == 0) begin
        exp_result = vin[chans[i-1]];
        exp_rchan  = chans[i-1];
        check_eq("done", done, 1);
        check_eq("last", last, (i == n) ? 1 : 0);
      end else begin
        check_eq("done_idle", done, 0);
        check_eq("last_idle", last, 0);
      end
      check_eq("result", result, exp_result);
      check_eq("result_chan", result_chan, exp_rchan);
      if (i == n) begin
        check_eq("busy_end", busy, 0);
        check_eq("sample_end", sample, 0);
        check_eq("dac_end", dac, 0);
      end else if (r < SampleCycles) begin
        check_eq("busy_smp", busy, 1);
        check_eq("sample_smp", sample, 1);
        check_eq("dac_smp", dac, 0);
        check_eq("chan_smp", chan, chans[i]);
      end else begin
        check_eq("busy_cnv", busy, 1);
        check_eq("sample_cnv", sample, 0);
        check_eq("dac_cnv", dac, trial(vin[chans[i]], r - SampleCycles));
        check_eq("chan_cnv", chan, chans[i]);
      end
    end
    start = 1'b0;
    @(posedge clk);
    #1;
    check_eq("busy_after", busy, 0);
    check_eq("done_after", done, 0);
  endtask

  task automatic run_abort(input int sel);
    @(negedge clk);
    start    = 1'b1;
    scan_in  = 1'b0;
    chan_sel = ChanW'(sel);
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (SampleCycles + 2) @(posedge clk);
    #1;
    check_eq("abort_pre_busy", busy, 1);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    check_eq("abort_busy", busy, 0);
    check_eq("abort_done", done, 0);
    check_eq("abort_sample", sample, 0);
    check_eq("abort_dac", dac, 0);
    check_eq("abort_result", result, exp_result);
    check_eq("abort_rchan", result_chan, exp_rchan);
    for (int k = 0; k < Period; k++) begin
      @(posedge clk);
      #1;
      check_eq("abort_no_done", done, 0);
      check_eq("abort_idle", busy, 0);
    end
  endtask

  task automatic run_reset();
    @(negedge clk);
    start   = 1'b1;
    scan_in = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (Period + SampleCycles + 2) @(posedge clk);
    #1;
    check_eq("rst_pre_chan", chan, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("rst_chan", chan, 0);
    check_eq("rst_sample", sample, 0);
    check_eq("rst_dac", dac, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_last", last, 0);
    check_eq("rst_result", result, 0);
    check_eq("rst_rchan", result_chan, 0);
    exp_result = 0;
    exp_rchan  = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check_eq("rst_stay_idle", busy, 0);
      check_eq("rst_stay_nosmp", sample, 0);
    end
  endtask

  initial begin
    int n;
    int poke;
    bit sc;
    total      = 0;
    bad        = 0;
    exp_result = 0;
    exp_rchan  = 0;
    rst_n      = 1'b0;
    start      = 1'b0;
    scan_in    = 1'b0;
    chan_sel   = '0;
    abort      = 1'b0;
    for (int k = 0; k < Channels; k++) vin[k] = 0;

    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_busy", busy, 0);
    check_eq("reset_sample", sample, 0);
    check_eq("reset_dac", dac, 0);
    check_eq("reset_done", done, 0);
    check_eq("reset_result", result, 0);
    check_eq("reset_chan", chan, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Scan with mixed codes, then single conversions covering edge codes.
    vin[0] = 5; vin[1] = 60; vin[2] = 31; vin[3] = 32;
    run_req(1'b1, 0, -1);
    vin[2] = 37;
    run_req(1'b0, 2, SampleCycles + 2);
    vin[0] = 0;
    run_req(1'b0, 0, Period - 1);
    vin[3] = 63;
    run_req(1'b0, 7, -1);
    run_abort(1);
    run_req(1'b0, 1, -1);
    run_reset();
    run_req(1'b0, 2, -1);

    for (int it = 0; it < 20; it++) begin
      for (int k = 0; k < Channels; k++) vin[k] = int'($urandom_range(0, (1 << Bits) - 1));
      sc   = 1'($urandom);
      n    = sc ? Channels : 1;
      poke = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, n * Period - 1)) : -1;
      run_req(sc, int'($urandom_range(0, 7)), poke);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
